// File: rtl/parking_input_conditioner.sv
// Sensor synchronize/debounce and two-digit password assembly feeding parking_system.
// Optional build macro KEYPAD_TIMEOUT_EN enables the digit-2 timeout and entry_error pulse.
module parking_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_entrance,
    input  logic       raw_exit,
    input  logic       key_valid,
    input  logic [1:0] key_digit,
    input  logic       key_clear,
    input  logic       pw_consume,
    output logic       sensor_entrance,
    output logic       sensor_exit,
    output logic [1:0] password_1,
    output logic [1:0] password_2,
    output logic       pw_ready,
    output logic       entry_error
);

    // state   | meaning
    // S_IDLE  | waiting for digit 1
    // S_WAIT2 | digit 1 held, waiting for digit 2
    // S_READY | both digits presented until pw_consume
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT2 = 2'd1,
        S_READY = 2'd2
    } state_t;

    localparam int             DW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0]  DLAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_db_out;
    logic [DW-1:0] r_db_cnt [2];

    assign w_raw           = {raw_exit, raw_entrance};
    assign sensor_entrance = r_db_out[0];
    assign sensor_exit     = r_db_out[1];

    // Each channel only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1  <= 2'b00;
            r_sync2  <= 2'b00;
            r_db_out <= 2'b00;
            for (int ch = 0; ch < 2; ch++) r_db_cnt[ch] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int ch = 0; ch < 2; ch++) begin
                if (r_sync2[ch] == r_db_out[ch]) begin
                    r_db_cnt[ch] <= '0;
                end else if (r_db_cnt[ch] == DLAST) begin
                    r_db_out[ch] <= ~r_db_out[ch];
                    r_db_cnt[ch] <= '0;
                end else begin
                    r_db_cnt[ch] <= r_db_cnt[ch] + DW'(1);
                end
            end
        end
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_d1;
    logic [1:0] r_d2;
    logic [1:0] w_d1_nxt;
    logic [1:0] w_d2_nxt;
    logic       r_pw_ready;
    logic [1:0] r_pw1;
    logic [1:0] r_pw2;
    logic       w_rdy_nxt;
    logic [1:0] w_pw1_nxt;
    logic [1:0] w_pw2_nxt;

`ifdef KEYPAD_TIMEOUT_EN
    localparam int            TW    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          w_expire;
    logic          r_entry_error;
    logic          w_err_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_d1       <= 2'b00;
            r_d2       <= 2'b00;
            r_pw_ready <= 1'b0;
            r_pw1      <= 2'b00;
            r_pw2      <= 2'b00;
`ifdef KEYPAD_TIMEOUT_EN
            r_timer       <= '0;
            r_entry_error <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_d1       <= w_d1_nxt;
            r_d2       <= w_d2_nxt;
            r_pw_ready <= w_rdy_nxt;
            r_pw1      <= w_pw1_nxt;
            r_pw2      <= w_pw2_nxt;
`ifdef KEYPAD_TIMEOUT_EN
            r_timer       <= w_timer_nxt;
            r_entry_error <= w_err_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_d1_nxt    = r_d1;
        w_d2_nxt    = r_d2;
`ifdef KEYPAD_TIMEOUT_EN
        w_timer_nxt = r_timer;
        w_expire    = 1'b0;
`endif
        if (key_clear) begin
            w_state_nxt = S_IDLE;
            w_d1_nxt    = 2'b00;
            w_d2_nxt    = 2'b00;
`ifdef KEYPAD_TIMEOUT_EN
            w_timer_nxt = '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (key_valid) begin
                        w_d1_nxt    = key_digit;
                        w_state_nxt = S_WAIT2;
`ifdef KEYPAD_TIMEOUT_EN
                        w_timer_nxt = '0;
`endif
                    end
                end
                S_WAIT2: begin
                    if (key_valid) begin
                        w_d2_nxt    = key_digit;
                        w_state_nxt = S_READY;
                    end
`ifdef KEYPAD_TIMEOUT_EN
                    // Timer holds at its last value on expiry rather than wrapping.
                    else if (r_timer == TLAST) begin
                        w_expire    = 1'b1;
                        w_d1_nxt    = 2'b00;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
`endif
                end
                S_READY: begin
                    if (pw_consume) begin
                        w_d1_nxt    = 2'b00;
                        w_d2_nxt    = 2'b00;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_d1_nxt    = 2'b00;
                    w_d2_nxt    = 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        w_rdy_nxt = (w_state_nxt == S_READY);
        w_pw1_nxt = w_rdy_nxt ? w_d1_nxt : 2'b00;
        w_pw2_nxt = w_rdy_nxt ? w_d2_nxt : 2'b00;
`ifdef KEYPAD_TIMEOUT_EN
        w_err_nxt = w_expire;
`endif
    end

    assign pw_ready   = r_pw_ready;
    assign password_1 = r_pw1;
    assign password_2 = r_pw2;

`ifdef KEYPAD_TIMEOUT_EN
    assign entry_error = r_entry_error;
`else
    assign entry_error = 1'b0;
`endif

endmodule
